demux_lanes: RTL and testbench

- Receive-side counterpart of the 4-lane priority mux: accepts the merged 12-bit word stream and steers each word to one of four output lanes selected by data_in[11:10].
- Each lane has a small FIFO with a valid/pop handshake toward its consumer.
- Generates backpressure (ready_in) toward the upstream mux and counts words it has to discard.
- A zero word is idle (same convention as the mux side): it is never written and never counted.

---
 rtl/demux_lanes_pkg.sv | 27 ++
 rtl/demux_lanes_if.sv | 39 +++
 rtl/demux_lane_fifo.sv | 64 ++++++
 rtl/demux_lanes.sv | 78 +++++++
 tb/tb_demux_lanes.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/demux_lanes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_lanes_pkg
// Brief    : Shared widths, lane IDs and lane-extraction helper for the
//            lane mux/demux pair.
// Revision : 1.0 - initial release
// ============================================================================
package demux_lanes_pkg;

    localparam int DATA_W  = 12;
    localparam int LANE_W  = 2;
    localparam int N_LANES = 4;

    typedef logic [LANE_W-1:0] lane_id_t;

    localparam lane_id_t LANE0 = 2'd0;
    localparam lane_id_t LANE1 = 2'd1;
    localparam lane_id_t LANE2 = 2'd2;
    localparam lane_id_t LANE3 = 2'd3;

    // The lane ID rides in the top bits of every word.
    function automatic lane_id_t lane_of(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: LANE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_lanes_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_lanes_if
// Brief    : Merged-stream input, per-lane consumer handshakes and drop count.
// Revision : 1.0 - initial release
// ============================================================================
interface demux_lanes_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic [DATA_W-1:0] data_out2;
    logic [DATA_W-1:0] data_out3;
    logic              valid_out0;
    logic              valid_out1;
    logic              valid_out2;
    logic              valid_out3;
    logic              pop0;
    logic              pop1;
    logic              pop2;
    logic              pop3;
    logic [CNT_W-1:0]  drop_count;

    modport master (
        output data_in, pop0, pop1, pop2, pop3,
        input  ready_in, data_out0, data_out1, data_out2, data_out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3, drop_count
    );

    modport slave (
        input  data_in, pop0, pop1, pop2, pop3,
        output ready_in, data_out0, data_out1, data_out2, data_out3,
        output valid_out0, valid_out1, valid_out2, valid_out3, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/demux_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : demux_lane_fifo
// Brief    : Per-lane FIFO with pop-through on full; fullness from a count.
// Revision : 1.0 - initial release
// ============================================================================
module demux_lane_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 2
) (
    input  wire logic              clk,
    input  wire logic              reset_L,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic              pop,
    output logic      [DATA_W-1:0] rdata,
    output logic                   valid,
    output logic                   full
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_full = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    logic w_do_pop;
    logic w_do_push;

    assign valid     = (r_count != '0);
    assign full      = (r_count == c_full);
    assign w_do_pop  = pop && valid;
    // A full lane still accepts a word when its head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/demux_lanes.sv
`default_nettype none
// ============================================================================
// Module   : demux_lanes
// Brief    : Steers the merged word stream into four lane FIFOs, drives
//            backpressure and counts discarded words.
// Revision : 1.0 - initial release
// ============================================================================
module demux_lanes #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  wire logic   clk,
    input  wire logic   reset_L,
    demux_lanes_if.slave bus
);
    import demux_lanes_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    lane_id_t          w_lane;
    logic              w_word_valid;
    logic [3:0]        w_push;
    logic [3:0]        w_pop;
    logic [3:0]        w_full;
    logic [3:0]        w_valid;
    logic [DATA_W-1:0] w_rdata [4];
    logic              w_drop;
    logic [CNT_W-1:0]  r_drop_count;

    assign w_lane       = lane_of(bus.data_in);
    assign w_word_valid = (bus.data_in != '0);
    assign w_pop        = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

    generate
        for (genvar i = 0; i < N_LANES; i++) begin : g_lane
            assign w_push[i] = w_word_valid && (w_lane == lane_id_t'(i));

            demux_lane_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset_L (reset_L),
                .push    (w_push[i]),
                .wdata   (bus.data_in),
                .pop     (w_pop[i]),
                .rdata   (w_rdata[i]),
                .valid   (w_valid[i]),
                .full    (w_full[i])
            );
        end
    endgenerate

    assign bus.data_out0  = w_rdata[0];
    assign bus.data_out1  = w_rdata[1];
    assign bus.data_out2  = w_rdata[2];
    assign bus.data_out3  = w_rdata[3];
    assign bus.valid_out0 = w_valid[0];
    assign bus.valid_out1 = w_valid[1];
    assign bus.valid_out2 = w_valid[2];
    assign bus.valid_out3 = w_valid[3];

    // Full flags come straight from FIFO count registers.
    assign bus.ready_in   = ~|w_full;
    assign bus.drop_count = r_drop_count;

    assign w_drop = w_word_valid && w_full[w_lane] && !w_pop[w_lane];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != c_cnt_max)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_demux_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_lanes
// Brief    : Directed and random stimulus against a queue-based lane model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_lanes;
    localparam int DEPTH = 2;

    logic clk;
    logic reset_L;

    demux_lanes_if #(.DATA_W(12), .CNT_W(8)) bus ();

    demux_lanes #(.DATA_W(12), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] od [4];
    logic        ov [4];
    assign od[0] = bus.data_out0;
    assign od[1] = bus.data_out1;
    assign od[2] = bus.data_out2;
    assign od[3] = bus.data_out3;
    assign ov[0] = bus.valid_out0;
    assign ov[1] = bus.valid_out1;
    assign ov[2] = bus.valid_out2;
    assign ov[3] = bus.valid_out3;

    logic [11:0] mq [4][$];
    int          mdrop;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string where);
        bit rdy;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s valid%0d", where, i), 32'(ov[i]), 32'(mq[i].size() > 0));
            chk($sformatf("%s data%0d", where, i), 32'(od[i]),
                (mq[i].size() > 0) ? 32'(mq[i][0]) : 32'd0);
            if (mq[i].size() >= DEPTH) rdy = 1'b0;
        end
        chk($sformatf("%s ready_in", where), 32'(bus.ready_in), 32'(rdy));
        chk($sformatf("%s drop_count", where), 32'(bus.drop_count), 32'(mdrop));
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input string where, input logic [11:0] d, input logic [3:0] p);
        bit popped [4];
        bit acc;
        int ln;
        bus.data_in = d;
        bus.pop0 = p[0];
        bus.pop1 = p[1];
        bus.pop2 = p[2];
        bus.pop3 = p[3];
        for (int i = 0; i < 4; i++) popped[i] = p[i] && (mq[i].size() > 0);
        acc = 1'b0;
        ln  = int'(d) / 1024;
        if (d != 12'd0) begin
            if (mq[ln].size() < DEPTH || popped[ln]) acc = 1'b1;
            else if (mdrop < 255) mdrop++;
        end
        for (int i = 0; i < 4; i++) if (popped[i]) void'(mq[i].pop_front());
        if (acc) mq[ln].push_back(d);
        @(posedge clk);
        #1;
        bus.data_in = 12'd0;
        bus.pop0 = 1'b0;
        bus.pop1 = 1'b0;
        bus.pop2 = 1'b0;
        bus.pop3 = 1'b0;
        check_model(where);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mdrop = 0;
    endtask

    initial begin
        logic [11:0] w;
        logic [3:0]  p;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        bus.data_in = 12'd0;
        bus.pop0 = 1'b0;
        bus.pop1 = 1'b0;
        bus.pop2 = 1'b0;
        bus.pop3 = 1'b0;
        reset_L = 1'b1;
        #2 reset_L = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_model("in_reset");
        reset_L = 1'b1;
        for (int k = 0; k < 10; k++) cycle("idle", 12'd0, 4'd0);

        // Routing by lane ID
        cycle("route0", 12'h001, 4'd0);
        chk("route0 data_out0", 32'(bus.data_out0), 32'h001);
        cycle("route1", 12'h402, 4'd0);
        chk("route1 data_out1", 32'(bus.data_out1), 32'h402);
        cycle("route2", 12'h803, 4'd0);
        chk("route2 data_out2", 32'(bus.data_out2), 32'h803);
        cycle("route3", 12'hC04, 4'd0);
        chk("route3 data_out3", 32'(bus.data_out3), 32'hC04);
        chk("route all valid", 32'({bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0}), 32'hF);
        cycle("drain", 12'd0, 4'hF);

        // Backpressure and drop on lane 1
        cycle("bp_push1", 12'h411, 4'd0);
        cycle("bp_push2", 12'h412, 4'd0);
        chk("bp ready_in low", 32'(bus.ready_in), 32'd0);
        cycle("bp_drop", 12'h413, 4'd0);
        chk("bp drop_count", 32'(bus.drop_count), 32'd1);
        chk("bp head kept", 32'(bus.data_out1), 32'h411);
        cycle("bp_pop1", 12'd0, 4'b0010);
        chk("bp second word", 32'(bus.data_out1), 32'h412);
        cycle("bp_pop2", 12'd0, 4'b0010);

        // Pop-through on a full lane
        cycle("pt_push1", 12'h411, 4'd0);
        cycle("pt_push2", 12'h412, 4'd0);
        cycle("pt_through", 12'h413, 4'b0010);
        chk("pt no drop", 32'(bus.drop_count), 32'd1);
        chk("pt head", 32'(bus.data_out1), 32'h412);
        cycle("pt_pop", 12'd0, 4'b0010);
        chk("pt last", 32'(bus.data_out1), 32'h413);
        cycle("pt_drain", 12'd0, 4'b0010);

        // Empty pop, then streaming through lane 2 across pointer wraps
        cycle("empty_pop2", 12'd0, 4'b0100);
        for (int k = 1; k <= 8; k++) begin
            w = 12'h800 | 12'(k);
            cycle("stream2", w, 4'b0100);
            chk("stream2 head", 32'(bus.data_out2), 32'(w));
        end
        cycle("stream_drain", 12'd0, 4'b0100);

        // Random traffic, mostly honouring backpressure
        for (int k = 0; k < 300; k++) begin
            w = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) w = 12'd0;
            if (!bus.ready_in && $urandom_range(0, 3) != 0) w = 12'd0;
            p = 4'($urandom);
            cycle("random", w, p);
        end
        cycle("rnd_drain", 12'd0, 4'hF);
        cycle("rnd_drain", 12'd0, 4'hF);

        // Saturate the drop counter on lane 3
        cycle("sat_fill", 12'hC51, 4'd0);
        cycle("sat_fill", 12'hC52, 4'd0);
        for (int k = 0; k < 300; k++) cycle("sat", 12'hC55, 4'd0);
        chk("sat drop_count", 32'(bus.drop_count), 32'd255);

        // Asynchronous reset between edges
        cycle("pre_rst", 12'h0A1, 4'd0);
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        chk("async_rst ready_in", 32'(bus.ready_in), 32'd1);
        @(posedge clk);
        #1 reset_L = 1'b1;
        for (int k = 0; k < 3; k++) cycle("post_rst", 12'd0, 4'd0);
        cycle("post_rst_push", 12'h805, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
